// File: rtl/logarithmic_converter_pipe.sv
// Two-stage elastic Mitchell linear-to-log converter producing {K, frac} words.
// Stage 1 finds the leading-one position; stage 2 left-aligns the mantissa bits below it.
module logarithmic_converter_pipe #(
  parameter int DataIN_width     = 16,
  parameter int truncation_width = 6,
  parameter int bw_lg            = $clog2(DataIN_width)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DataIN_width-1:0]              in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [bw_lg+truncation_width+1:0]    out_log,
  output logic                                 out_zero
);

  localparam int KW = bw_lg + 1;
  localparam int FW = truncation_width + 1;
  localparam int XW = DataIN_width + FW;

  logic                    s1_valid;
  logic [DataIN_width-1:0] s1_data;
  logic [KW-1:0]           s1_k;
  logic                    s1_zero;
  logic                    s2_advance;

  logic [KW-1:0]           lod_k;
  logic [KW-1:0]           shamt;
  logic [XW-1:0]           aligned;
  logic [FW-1:0]           frac;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  // Priority leading-one detector: the highest set bit wins.
  always_comb begin
    lod_k = '0;
    for (int unsigned i = 0; i < DataIN_width; i++) begin
      if (in_data[i]) lod_k = KW'(i);
    end
  end

  // Shifting {data, zero pad} left by W-K pushes the leading one out of the top and
  // leaves data[K-1:0] left-aligned; the top FW bits are the floor-truncated fraction.
  always_comb begin
    shamt   = KW'(DataIN_width) - s1_k;
    aligned = {s1_data, {FW{1'b0}}} << shamt;
    frac    = FW'(aligned >> DataIN_width);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_k     <= '0;
      s1_zero  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_k    <= lod_k;
        s1_zero <= (in_data == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_log   <= '0;
      out_zero  <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_zero <= s1_zero;
        out_log  <= s1_zero ? '0 : {s1_k, frac};
      end
    end
  end

endmodule

// File: tb/tb_logarithmic_converter_pipe.sv
// Bench for logarithmic_converter_pipe: arithmetic log2 model, queue scoreboard,
// directed vectors and randomized traffic with backpressure.
module tb_logarithmic_converter_pipe;
  localparam int W  = 16;
  localparam int TW = 6;
  localparam int BW = 4;
  localparam int LW = BW + TW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [LW-1:0] out_log;
  logic          out_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int delivered = 0;
  logic [LW:0] exp_q[$];

  always #5 clk = ~clk;

  logarithmic_converter_pipe #(
    .DataIN_width(W),
    .truncation_width(TW),
    .bw_lg(BW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_log(out_log),
    .out_zero(out_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {zero, K, frac}: K = floor(log2 x), frac = floor((x - 2^K) * 2^(TW+1) / 2^K)
  function automatic logic [LW:0] ref_conv(input int unsigned x);
    int unsigned k;
    longint unsigned f;
    if (x == 0) return {1'b1, {LW{1'b0}}};
    k = 0;
    while ((x >> (k + 1)) != 0) k++;
    f = ((longint'(x) - (longint'(1) << k)) << (TW + 1)) >> k;
    return {1'b0, LW'((longint'(k) << (TW + 1)) | f)};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          check("out_log", 32'(out_log), 32'(exp_q[0][LW-1:0]));
          check("out_zero", 32'(out_zero), 32'(exp_q[0][LW]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            delivered++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_conv(in_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic single(input logic [W-1:0] x, input logic [LW-1:0] e_log, input logic e_zero);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
    check("lat1_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat2_out_valid", 32'(out_valid), 32'd1);
    check("lit_out_log", 32'(out_log), 32'(e_log));
    check("lit_out_zero", 32'(out_zero), 32'(e_zero));
    idle(2);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom >> $urandom_range(16, 31));
    endcase
  endfunction

  initial begin
    int low, acc, d0, guard;
    logic acc_b;

    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_log", 32'(out_log), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    check("model_0001", 32'(ref_conv(1)), 32'h0000);
    check("model_00C0", 32'(ref_conv('h00C0)), 32'h03C0);
    check("model_0003", 32'(ref_conv(3)), 32'h00C0);
    check("model_FFFF", 32'(ref_conv('hFFFF)), 32'h07FF);
    check("model_0000", 32'(ref_conv(0)), 32'h1000);

    idle(2);
    single(16'h0001, 12'h000, 1'b0);
    single(16'h00C0, 12'h3C0, 1'b0);
    single(16'h0003, 12'h0C0, 1'b0);
    single(16'hFFFF, 12'h7FF, 1'b0);
    single(16'h0000, 12'h000, 1'b1);

    // Full-rate stream
    d0 = delivered;
    low = 0;
    in_valid = 1'b1;
    for (int v = 1; v <= 256; v++) begin
      in_data = W'(v);
      if (!in_ready) low++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("stream_in_ready_low", 32'(low), 32'd0);
    check("stream_delivered", 32'(delivered - d0), 32'd256);
    idle(2);

    // Backpressure from empty: exactly two accepts while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = W'(16'h1230 + i * 16'h0111);
      if (in_ready) acc++;
      tick();
    end
    check("stall_accepts", 32'(acc), 32'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0ABC;
    repeat (3) tick();
    in_valid = 1'b0;
    #1;
    check("full_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_log", 32'(out_log), 32'd0);
    check("midrst_out_zero", 32'(out_zero), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    single(16'h0003, 12'h0C0, 1'b0);

    // Randomized traffic; in_data held until accepted
    acc_b = 1'b0;
    repeat (2000) begin
      if (!in_valid || acc_b) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rand_operand();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_b = in_valid && in_ready;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
